// File: rtl/wsat_ucb_pkg.sv
// wsat_ucb_pkg: shared types and helpers for the unsatisfied-clause buffer.
//   CLAUSE_W  width of one packed 3-literal clause
//   NUM_SLOT  slots per newly-unsatisfied burst from the clause table
//   slot_of() picks slot k (1-based, slot 1 in the top bits) out of a burst bus
package wsat_ucb_pkg;
    localparam int CLAUSE_W   = 36;
    localparam int NUM_SLOT   = 20;
    localparam int BUS_W      = CLAUSE_W * NUM_SLOT;
    localparam int SLOT_IDX_W = $clog2(NUM_SLOT);

    typedef logic [CLAUSE_W-1:0] clause_t;
    typedef logic [NUM_SLOT-1:0] slot_mask_t;

    // Capture stage: DRAIN pushes one clause per cycle; TAIL is the extra
    // cycle before the stage reports ready again.
    typedef enum logic [1:0] {
        CAP_IDLE  = 2'd0,
        CAP_DRAIN = 2'd1,
        CAP_TAIL  = 2'd2
    } cap_state_t;

    // Slot k lives at bus[36*(20-k)+35 -: 36], so slot 1 is the top field.
    function automatic clause_t slot_of(input logic [BUS_W-1:0] bus, input int k);
        slot_of = bus[CLAUSE_W*(NUM_SLOT-k) +: CLAUSE_W];
    endfunction
endpackage

// File: rtl/ucb_rr_arb.sv
// ucb_rr_arb: round-robin arbiter for the UCB clause-register requesters.
//   clk, rst   clock, synchronous active-high reset
//   clr        synchronous flush: pointer back to requester 1, grant cleared
//   en         a pop is possible this cycle (FIFO non-empty, no flush)
//   req        per-requester level requests
//   gnt_nxt    combinational winner for this cycle (drives the FIFO pop)
//   gnt        registered one-hot grant, visible the cycle after the decision
// The registered grant doubles as the one-cycle grantee mask: a requester sees
// its grant one cycle late, so its request is still up for one more edge.
module ucb_rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt_nxt,
    output logic [NUM_REQ-1:0] gnt
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      win;
    logic               found;
    logic [NUM_REQ-1:0] elig;

    assign elig = req & ~gnt;

    // First eligible requester at or after the pointer, wrapping.
    always_comb begin
        gnt_nxt = '0;
        win     = ptr;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (en && !found && elig[(int'(ptr) + i) % NUM_REQ]) begin
                found = 1'b1;
                win   = PW'((int'(ptr) + i) % NUM_REQ);
            end
        end
        if (found) gnt_nxt[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
            gnt <= '0;
        end else begin
            gnt <= gnt_nxt;
            if (found) ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end
    end
endmodule

// File: rtl/ucb_collector.sv
// ucb_collector: unsatisfied-clause buffer for the WalkSAT table pipeline.
// Captures a 20-slot burst (mask + 720-bit bus), serialises the set slots into
// a circular clause FIFO (slot 1 first), and serves stored clauses to NUM_REQ
// clause registers through a round-robin grant.
//   clk, rst    clock, synchronous active-high reset
//   clr         flush FIFO, capture stage and arbiter (sticky flags kept)
//   write_req   burst slot mask, bit 19 = slot 1 ... bit 0 = slot 20
//   clause_in   burst clause bus, slot 1 in [719:684]
//   wr_ready    capture stage idle
//   ucb_req     per-requester level requests
//   ucb_gnt     one-hot registered grant, reg_out valid in the same cycle
//   reg_out     granted clause
//   empty       FIFO empty
//   count       FIFO occupancy
//   lost_burst  sticky: burst arrived while busy
//   fifo_ovf    sticky: clause dropped on a full FIFO
// Optional build macro UCB_STATS_EN adds push_cnt, pop_cnt and hwm
// (occupancy high-water mark), all cleared by rst and clr.
module ucb_collector
    import wsat_ucb_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic [NUM_SLOT-1:0]    write_req,
    input  logic [BUS_W-1:0]       clause_in,
    output logic                   wr_ready,
    input  logic [NUM_REQ-1:0]     ucb_req,
    output logic [NUM_REQ-1:0]     ucb_gnt,
    output logic [CLAUSE_W-1:0]    reg_out,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   lost_burst,
`ifdef UCB_STATS_EN
    output logic                   fifo_ovf,
    output logic [31:0]            push_cnt,
    output logic [31:0]            pop_cnt,
    output logic [$clog2(DEPTH):0] hwm
`else
    output logic                   fifo_ovf
`endif
);
    localparam int             AW   = $clog2(DEPTH);
    localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);

    // ---------------- capture / drain ----------------
    cap_state_t              state;
    slot_mask_t              mask;
    slot_mask_t              sel_oh;
    slot_mask_t              mask_rest;
    logic [SLOT_IDX_W-1:0]   sel_bit;
    logic [BUS_W-1:0]        bus_q;
    clause_t                 push_data;
    logic                    burst_in;
    logic                    cap_fire;
    logic                    push_en;

    assign burst_in = |write_req;
    assign cap_fire = !clr && wr_ready && burst_in;
    assign push_en  = !clr && (state == CAP_DRAIN);

    // Lowest slot number = highest set mask bit.
    always_comb begin
        sel_bit = '0;
        for (int b = 0; b < NUM_SLOT; b++) begin
            if (mask[b]) sel_bit = SLOT_IDX_W'(b);
        end
    end

    assign sel_oh    = slot_mask_t'(1) << sel_bit;
    assign mask_rest = mask & ~sel_oh;
    assign push_data = slot_of(bus_q, NUM_SLOT - int'(sel_bit));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state    <= CAP_IDLE;
            mask     <= '0;
            wr_ready <= 1'b1;
        end else begin
            case (state)
                CAP_IDLE: begin
                    if (burst_in) begin
                        mask     <= write_req;
                        wr_ready <= 1'b0;
                        state    <= CAP_DRAIN;
                    end
                end
                CAP_DRAIN: begin
                    // The bit clears even if the FIFO drops the clause.
                    mask <= mask_rest;
                    if (mask_rest == '0) state <= CAP_TAIL;
                end
                CAP_TAIL: begin
                    wr_ready <= 1'b1;
                    state    <= CAP_IDLE;
                end
                default: begin
                    state    <= CAP_IDLE;
                    mask     <= '0;
                    wr_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cap_fire) bus_q <= clause_in;
    end

    // ---------------- arbitration ----------------
    logic [NUM_REQ-1:0] gnt_nxt;
    logic               arb_en;
    logic               pop;

    assign empty  = (count == '0);
    assign arb_en = !empty && !clr;
    assign pop    = |gnt_nxt;

    ucb_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .en      (arb_en),
        .req     (ucb_req),
        .gnt_nxt (gnt_nxt),
        .gnt     (ucb_gnt)
    );

    // ---------------- FIFO ----------------
    clause_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count_nxt;
    logic           full;
    logic           push_ok;
    logic           push_drop;

    assign full      = (count == FULL);
    // A same-cycle pop frees the slot, so a push on a full FIFO still lands.
    assign push_ok   = push_en && (!full || pop);
    assign push_drop = push_en && full && !pop;

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop)      count_nxt = count + 1'b1;
        else if (!push_ok && pop) count_nxt = count - 1'b1;
    end

    // Read-before-write: with full push+pop the pointers alias and the read
    // must see the old entry.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            reg_out <= '0;
        end else begin
            count <= count_nxt;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                reg_out <= mem[rd_ptr];
            end
        end
    end

    // ---------------- sticky flags ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            lost_burst <= 1'b0;
            fifo_ovf   <= 1'b0;
        end else begin
            if (!clr && !wr_ready && burst_in) lost_burst <= 1'b1;
            if (push_drop)                     fifo_ovf   <= 1'b1;
        end
    end

`ifdef UCB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            push_cnt <= '0;
            pop_cnt  <= '0;
            hwm      <= '0;
        end else begin
            if (push_ok)         push_cnt <= push_cnt + 1'b1;
            if (pop)             pop_cnt  <= pop_cnt + 1'b1;
            if (count_nxt > hwm) hwm      <= count_nxt;
        end
    end
`endif
endmodule

// File: tb/tb_ucb_collector.sv
// Directed bench for ucb_collector: a DEPTH=1024 instance for the main flow
// and a DEPTH=4 instance for full-FIFO corner cases.
module tb_ucb_collector;
    import wsat_ucb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, clr;
    logic [NUM_SLOT-1:0] write_req;
    logic [BUS_W-1:0]    clause_in;
    logic [3:0]          ucb_req;
    logic                wr_ready, empty, lost_burst, fifo_ovf;
    logic [3:0]          ucb_gnt;
    clause_t             reg_out;
    logic [10:0]         count;

    logic [NUM_SLOT-1:0] s_write_req;
    logic [BUS_W-1:0]    s_clause_in;
    logic [3:0]          s_ucb_req;
    logic                s_wr_ready, s_empty, s_lost_burst, s_fifo_ovf;
    logic [3:0]          s_ucb_gnt;
    clause_t             s_reg_out;
    logic [2:0]          s_count;
`ifdef UCB_STATS_EN
    logic [31:0] push_cnt, pop_cnt, s_push_cnt, s_pop_cnt;
    logic [10:0] hwm;
    logic [2:0]  s_hwm;
`endif

    int n_run  = 0;
    int n_fail = 0;
    int peak   = 0;

    ucb_collector #(.DEPTH(1024), .NUM_REQ(4)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .write_req(write_req), .clause_in(clause_in),
        .wr_ready(wr_ready), .ucb_req(ucb_req), .ucb_gnt(ucb_gnt), .reg_out(reg_out),
        .empty(empty), .count(count), .lost_burst(lost_burst),
`ifdef UCB_STATS_EN
        .push_cnt(push_cnt), .pop_cnt(pop_cnt), .hwm(hwm),
`endif
        .fifo_ovf(fifo_ovf)
    );

    ucb_collector #(.DEPTH(4), .NUM_REQ(4)) u_small (
        .clk(clk), .rst(rst), .clr(clr), .write_req(s_write_req), .clause_in(s_clause_in),
        .wr_ready(s_wr_ready), .ucb_req(s_ucb_req), .ucb_gnt(s_ucb_gnt), .reg_out(s_reg_out),
        .empty(s_empty), .count(s_count), .lost_burst(s_lost_burst),
`ifdef UCB_STATS_EN
        .push_cnt(s_push_cnt), .pop_cnt(s_pop_cnt), .hwm(s_hwm),
`endif
        .fifo_ovf(s_fifo_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic clause_t mk(input int tag, input int k);
        return {8'(tag), 20'h0, 8'(k)};
    endfunction

    function automatic logic [BUS_W-1:0] build_bus(input int tag);
        logic [BUS_W-1:0] b;
        b = '0;
        for (int k = 1; k <= NUM_SLOT; k++) b[CLAUSE_W*(NUM_SLOT-k) +: CLAUSE_W] = mk(tag, k);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (int'(count) > peak) peak = int'(count);
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 100 && !wr_ready; i++) tick();
        chk(tag, wr_ready, 1);
    endtask

    logic [3:0] exp_gnt [5];
    clause_t    exp_dat [5];

    initial begin
        rst = 1'b1; clr = 1'b0; write_req = '0; clause_in = '0; ucb_req = '0;
        s_write_req = '0; s_clause_in = '0; s_ucb_req = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ready", wr_ready, 1);
        chk("rst_gnt", ucb_gnt, 0);
        chk("rst_regout", reg_out, 0);
        chk("rst_lost", lost_burst, 0);
        chk("rst_ovf", fifo_ovf, 0);
        chk("rst_s_count", s_count, 0);

        // burst slots 1,3,20
        clause_in = build_bus(1);
        write_req = 20'hA0001;
        tick();
        write_req = '0;
        chk("b1_rdy_c0", wr_ready, 0); chk("b1_cnt_c0", count, 0);
        tick(); chk("b1_rdy_c1", wr_ready, 0); chk("b1_cnt_c1", count, 1);
        tick(); chk("b1_rdy_c2", wr_ready, 0); chk("b1_cnt_c2", count, 2);
        tick(); chk("b1_rdy_c3", wr_ready, 0); chk("b1_cnt_c3", count, 3);
        tick(); chk("b1_rdy_c4", wr_ready, 1); chk("b1_cnt_c4", count, 3);

        // slots 5,7, then round-robin drain of all five
        clause_in = build_bus(2);
        write_req = 20'h0A000;
        tick();
        write_req = '0;
        wait_ready("b2_ready");
        chk("b2_count", count, 5);
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_dat = '{mk(1,1), mk(1,3), mk(1,20), mk(2,5), mk(2,7)};
        ucb_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rr_gnt%0d", i), ucb_gnt, exp_gnt[i]);
            chk($sformatf("rr_dat%0d", i), reg_out, exp_dat[i]);
        end
        chk("rr_empty", empty, 1);
        ucb_req = '0;
        tick();
        chk("rr_gnt_idle", ucb_gnt, 0);

        // second burst while busy is dropped
        clause_in = build_bus(3);
        write_req = 20'hFFFFF;
        tick();
        write_req = 20'h00003;
        tick();
        write_req = '0;
        chk("lost_set", lost_burst, 1);
        wait_ready("b3_ready");
        chk("b3_count", count, 20);
        ucb_req = 4'b0100;
        tick();
        ucb_req = '0;
        chk("b3_gnt", ucb_gnt, 4'b0100);
        chk("b3_dat", reg_out, mk(3,1));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr1_count", count, 0);
        chk("clr1_lost", lost_burst, 1);

        // clr mid-drain: 19-bit burst, 7 pushed, 12 left
        clause_in = build_bus(4);
        write_req = 20'hFFFFE;
        tick();
        write_req = '0;
        repeat (7) tick();
        chk("cm_count7", count, 7);
        ucb_req = 4'b0001;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ucb_req = '0;
        chk("cm_count", count, 0);
        chk("cm_ready", wr_ready, 1);
        chk("cm_gnt", ucb_gnt, 0);
        chk("cm_lost", lost_burst, 1);
        chk("cm_ovf", fifo_ovf, 0);
        tick();
        chk("cm_count_after", count, 0);

        // DEPTH=4 corner: full push+pop, then overflow
        s_clause_in = build_bus(5);
        s_write_req = 20'hF0000;
        tick();
        s_write_req = '0;
        for (int i = 0; i < 50 && !s_wr_ready; i++) tick();
        chk("sm_ready", s_wr_ready, 1);
        chk("sm_full", s_count, 4);
        chk("sm_ovf0", s_fifo_ovf, 0);
        s_clause_in = build_bus(6);
        s_write_req = 20'h00003;
        tick();
        s_write_req = '0;
        s_ucb_req = 4'b0001;
        tick();
        s_ucb_req = '0;
        chk("sm_pp_count", s_count, 4);
        chk("sm_pp_gnt", s_ucb_gnt, 4'b0001);
        chk("sm_pp_dat", s_reg_out, mk(5,1));
        chk("sm_pp_ovf", s_fifo_ovf, 0);
        tick();
        chk("sm_ovf1", s_fifo_ovf, 1);
        chk("sm_ovf_count", s_count, 4);

`ifdef UCB_STATS_EN
        clr = 1'b1;
        tick();
        clr = 1'b0;
        peak = 0;
        chk("st_clr_push", push_cnt, 0);
        for (int b = 0; b < 3; b++) begin
            clause_in = build_bus(7 + b);
            write_req = 20'h00003;
            tick();
            write_req = '0;
            wait_ready($sformatf("st_ready%0d", b));
        end
        ucb_req = 4'b1111;
        repeat (4) tick();
        ucb_req = '0;
        tick();
        chk("st_push", push_cnt, 6);
        chk("st_pop", pop_cnt, 4);
        chk("st_hwm", hwm, 64'(peak));
        chk("st_count", count, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
